// File: rtl/alarma_pkg.sv
// alarma_pkg: shared state encoding and default parameters of the countdown alarm timer
package alarma_pkg;
  typedef enum logic [1:0] {IDLE, NUMARA, SUNA} stare_t;
  localparam int PRESCALE_DEF   = 50_000_000;
  localparam int CNT_W_DEF      = 16;
  localparam int RING_SEC_DEF   = 10;
  localparam int DEB_CYCLES_DEF = 500_000;
endpackage

// File: rtl/temporizator_alarma_if.sv
// temporizator_alarma_if: control/status bundle between the front panel and the alarm timer
interface temporizator_alarma_if #(parameter int CNT_W = alarma_pkg::CNT_W_DEF);
  logic             start;
  logic [CNT_W-1:0] durata;
  logic             oprire;
  logic             semnal;
  logic             activ;
  logic [CNT_W-1:0] ramas;
  logic             gata;
  modport master (output start, durata, oprire, input semnal, activ, ramas, gata);
  modport slave  (input start, durata, oprire, output semnal, activ, ramas, gata);
endinterface

// File: rtl/debounce_buton.sv
// debounce_buton: synchronizes a raw button, accepts a level after DEB_CYCLES stable cycles, pulses on press
module debounce_buton
  import alarma_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic nivel,
  output logic apasat
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);
  logic s1_q, s2_q, nivel_q, apasat_q;
  logic [DW-1:0] cnt_q;
  logic schimba, accept;
  assign schimba = s2_q != nivel_q;
  assign accept  = schimba && (cnt_q == DEB_MAX);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      nivel_q  <= 1'b0;
      apasat_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= in;
      s2_q     <= s1_q;
      cnt_q    <= (schimba && !accept) ? cnt_q + 1'b1 : '0;
      nivel_q  <= accept ? s2_q : nivel_q;
      apasat_q <= accept && s2_q;
    end
  end
  assign nivel  = nivel_q;
  assign apasat = apasat_q;
endmodule

// File: rtl/temporizator_alarma.sv
// temporizator_alarma: countdown on a prescaled second tick, then ring request for RING_SEC ticks
module temporizator_alarma
  import alarma_pkg::*;
#(
  parameter int PRESCALE   = PRESCALE_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int RING_SEC   = RING_SEC_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input logic clock,
  input logic reset,
  temporizator_alarma_if.slave bus
);
  localparam int PW = $clog2(PRESCALE);
  localparam int RW = $clog2(RING_SEC + 1);
  localparam logic [PW-1:0] PRE_MAX   = PW'(PRESCALE - 1);
  localparam logic [RW-1:0] RING_INIT = RW'(RING_SEC);
  stare_t           stare_q;
  logic [CNT_W-1:0] ramas_q;
  logic             semnal_q, activ_q, gata_q;
  logic [PW-1:0]    pre_q;
  logic [RW-1:0]    ring_q;
  logic nivel, apasat, anulare, tick, incarca;
  debounce_buton #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clock  (clock),
    .reset  (reset),
    .in     (bus.oprire),
    .nivel  (nivel),
    .apasat (apasat)
  );
  assign anulare = apasat & nivel;
  assign tick    = (stare_q != IDLE) && (pre_q == PRE_MAX);
  assign incarca = bus.start && (bus.durata != '0);
  // Priority is cancel > reload > tick; the prescaler restarts on every state entry and reload
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stare_q  <= IDLE;
      ramas_q  <= '0;
      semnal_q <= 1'b0;
      activ_q  <= 1'b0;
      gata_q   <= 1'b0;
      pre_q    <= '0;
      ring_q   <= '0;
    end else begin
      gata_q <= 1'b0;
      pre_q  <= (stare_q == IDLE || tick || anulare || (stare_q == NUMARA && incarca)) ? '0 : pre_q + 1'b1;
      case (stare_q)
        IDLE: if (incarca) begin
          stare_q <= NUMARA;
          ramas_q <= bus.durata;
          activ_q <= 1'b1;
        end
        NUMARA: if (anulare) begin
          stare_q <= IDLE;
          ramas_q <= '0;
          activ_q <= 1'b0;
        end else if (incarca) begin
          ramas_q <= bus.durata;
        end else if (tick) begin
          if (ramas_q > CNT_W'(1)) ramas_q <= ramas_q - 1'b1;
          else begin
            ramas_q  <= '0;
            stare_q  <= SUNA;
            semnal_q <= 1'b1;
            ring_q   <= RING_INIT;
          end
        end
        SUNA: if (anulare) begin
          stare_q  <= IDLE;
          semnal_q <= 1'b0;
          activ_q  <= 1'b0;
          ring_q   <= '0;
        end else if (tick) begin
          if (ring_q == RW'(1)) begin
            stare_q  <= IDLE;
            semnal_q <= 1'b0;
            activ_q  <= 1'b0;
            gata_q   <= 1'b1;
            ring_q   <= '0;
          end else ring_q <= ring_q - 1'b1;
        end
        default: stare_q <= IDLE;
      endcase
    end
  end
  assign bus.semnal = semnal_q;
  assign bus.activ  = activ_q;
  assign bus.ramas  = ramas_q;
  assign bus.gata   = gata_q;
endmodule

// File: tb/tb_temporizator_alarma.sv
// tb_temporizator_alarma: vector table plus hand sequences for cancel/bounce and async reset
module tb_temporizator_alarma;
  localparam int P = 4, R = 3, D = 2, W = 16;
  logic clock = 1'b0, reset = 1'b1;
  always #5 clock = ~clock;
  temporizator_alarma_if #(.CNT_W(W)) bus ();
  temporizator_alarma #(.PRESCALE(P), .CNT_W(W), .RING_SEC(R), .DEB_CYCLES(D)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );
  typedef struct packed {logic semnal; logic activ; logic [W-1:0] ramas; logic gata;} out_t;
  typedef struct {string nm; int n; logic start; logic [W-1:0] durata; logic oprire; out_t e;} vec_t;
  vec_t tbl[$];
  out_t sb[$];
  int checks = 0, failures = 0, cyc = 0, gatas = 0;
  bit done;
  function automatic out_t o(logic s, logic a, logic [W-1:0] r, logic g);
    return {s, a, r, g};
  endfunction
  function automatic out_t act();
    return {bus.semnal, bus.activ, bus.ramas, bus.gata};
  endfunction
  task automatic check(string nm, out_t got, out_t want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s @%0t: got semnal=%0b activ=%0b ramas=%0d gata=%0b, want semnal=%0b activ=%0b ramas=%0d gata=%0b",
               nm, $time, got.semnal, got.activ, got.ramas, got.gata, want.semnal, want.activ, want.ramas, want.gata);
    end
  endtask
  task automatic step(string nm, logic st, logic [W-1:0] d, logic op, out_t e);
    bus.start = st; bus.durata = d; bus.oprire = op;
    sb.push_back(e);
    @(posedge clock); #1;
    check(nm, act(), sb.pop_front());
  endtask
  task automatic add(string nm, int n, logic st, logic [W-1:0] d, logic op, logic s, logic a, logic [W-1:0] r, logic g);
    tbl.push_back('{nm, n, st, d, op, o(s, a, r, g)});
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    bus.start = 1'b0; bus.durata = '0; bus.oprire = 1'b0;
    add("run_start", 1, 1, 2, 0, 0, 1, 2, 0);
    add("run_r2",    3, 0, 0, 0, 0, 1, 2, 0);
    add("run_r1",    4, 0, 0, 0, 0, 1, 1, 0);
    add("run_ring", 12, 0, 0, 0, 1, 1, 0, 0);
    add("run_gata",  1, 0, 0, 0, 0, 0, 0, 1);
    add("run_idle",  3, 0, 0, 0, 0, 0, 0, 0);
    add("zero_start", 1, 1, 0, 0, 0, 0, 0, 0);
    add("zero_idle", 20, 0, 0, 0, 0, 0, 0, 0);
    add("rl_start",  1, 1, 5, 0, 0, 1, 5, 0);
    add("rl_r5",     3, 0, 0, 0, 0, 1, 5, 0);
    add("rl_r4",     4, 0, 0, 0, 0, 1, 4, 0);
    add("rl_r3",     1, 0, 0, 0, 0, 1, 3, 0);
    add("rl_reload", 1, 1, 2, 0, 0, 1, 2, 0);
    add("rl_r2",     3, 0, 0, 0, 0, 1, 2, 0);
    add("rl_r1",     4, 0, 0, 0, 0, 1, 1, 0);
    add("rl_ring",   1, 0, 0, 0, 1, 1, 0, 0);
    add("rl_ign",    1, 1, 9, 0, 1, 1, 0, 0);
    add("rl_ring2", 10, 0, 0, 0, 1, 1, 0, 0);
    add("rl_gata",   1, 0, 0, 0, 0, 0, 0, 1);
    add("rl_idle",   2, 0, 0, 0, 0, 0, 0, 0);
    add("sim_start", 1, 1, 9, 0, 0, 1, 9, 0);
    add("sim_press", 3, 0, 0, 1, 0, 1, 9, 0);
    add("sim_tick",  1, 0, 0, 1, 0, 1, 8, 0);
    add("sim_both",  1, 1, 7, 1, 0, 0, 0, 0);
    add("sim_hold",  2, 0, 0, 1, 0, 0, 0, 0);
    add("sim_rel",   8, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1 check("reset", act(), o(0, 0, 0, 0));
    reset = 1'b0;
    foreach (tbl[i])
      for (int k = 0; k < tbl[i].n; k++) step(tbl[i].nm, tbl[i].start, tbl[i].durata, tbl[i].oprire, tbl[i].e);
    step("cb_start", 1, 1, 0, o(0, 1, 1, 0));
    repeat (3) step("cb_cnt", 0, 0, 0, o(0, 1, 1, 0));
    step("cb_ring", 0, 0, 0, o(1, 1, 0, 0));
    for (int i = 0; i < 4; i++) step("cb_glitch", 0, 0, (i % 2) == 0, o(1, 1, 0, 0));
    bus.oprire = 1'b1;
    done = 1'b0;
    while (!done && cyc < D + 4) begin
      @(posedge clock); #1;
      cyc++;
      gatas += int'(bus.gata);
      done = !bus.semnal && !bus.activ;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL cancel_latency: semnal=%0b activ=%0b after %0d cycles, want both 0 within %0d", bus.semnal, bus.activ, cyc, D + 4);
    end
    repeat (6) begin
      @(posedge clock); #1;
      gatas += int'(bus.gata);
    end
    checks++;
    if (gatas != 0) begin
      failures++;
      $display("FAIL cancel_no_gata: gata pulsed %0d times, want 0", gatas);
    end
    repeat (8) step("cb_rel", 0, 0, 0, o(0, 0, 0, 0));
    step("ar_start", 1, 1, 0, o(0, 1, 1, 0));
    repeat (3) step("ar_cnt", 0, 0, 0, o(0, 1, 1, 0));
    step("ar_ring", 0, 0, 0, o(1, 1, 0, 0));
    #3 reset = 1'b1;
    #1 check("async_reset", act(), o(0, 0, 0, 0));
    @(posedge clock); #1 reset = 1'b0;
    repeat (10) step("ar_idle", 0, 0, 0, o(0, 0, 0, 0));
    step("ar_restart", 1, 3, 0, o(0, 1, 3, 0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/temporizator_alarma.md
Name: temporizator_alarma

Overview:
- Countdown alarm timer. It is the stage directly upstream of the buzzer/LED blink stage and generates that stage's `semnal` ring-request input.
- The user loads a duration in seconds and starts the timer. The block counts down on a prescaled one-second tick, then holds `semnal` high for a fixed ring period.
- A debounced push-button (`oprire`) cancels the countdown or the ring at any time.

Parameters:
- PRESCALE, 50_000_000: clock cycles per one-second tick (must be ≥2).
- CNT_W, 16: width of the seconds counter and of `durata`/`ramas`.
- RING_SEC, 10: ring duration in ticks (≥1).
- DEB_CYCLES, 500_000: cycles `oprire` must be stable before it is accepted.

Ports:
- clock, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: synchronous one-cycle start/reload request.
- durata, input, CNT_W: countdown length in seconds, sampled when `start` is accepted.
- oprire, input, 1: raw, asynchronous, bouncing cancel button, active-high.
- semnal, output, 1: ring request to the downstream blink stage; registered.
- activ, output, 1: high while in NUMARA or SUNA; registered.
- ramas, output, CNT_W: seconds remaining; registered.
- gata, output, 1: one-cycle pulse when a ring period completes by timeout; registered.

Behaviour:
- Reset (async assert, sync release):
  - State is IDLE.
  - Outputs: `semnal`=0, `activ`=0, `ramas`=0, `gata`=0.
  - Prescaler counter, ring counter and debouncer all cleared.
  - Reset mid-operation aborts immediately with no `gata` pulse.
- Cancel input conditioning:
  - `oprire` passes through a 2-FF synchronizer, then the debouncer.
  - The debounced level must stay stable for DEB_CYCLES consecutive cycles before it changes.
  - A 0→1 transition of the debounced level produces a one-cycle `anulare` pulse.
  - Latency from a clean press to `anulare` is DEB_CYCLES+3 cycles (±1).
- Prescaler:
  - Counts 0..PRESCALE-1 only in NUMARA and SUNA.
  - `tick` asserts for one cycle when the count equals PRESCALE-1, then the count wraps to 0.
  - Cleared on every state entry, so the first tick after entry arrives exactly PRESCALE cycles later.
- State machine (transitions registered; outputs reflect the new state in the same edge):
  - IDLE:
    - `start` with `durata`≠0 → NUMARA; `ramas`←`durata`; `activ`←1.
    - `start` with `durata`=0 is ignored.
  - NUMARA:
    - `anulare` → IDLE; `ramas`←0; `activ`←0.
    - `start` with `durata`≠0 reloads: `ramas`←`durata` and the prescaler clears.
    - `start` with `durata`=0 is ignored.
    - On `tick`, if `ramas`>1: `ramas`←`ramas`-1.
    - On `tick`, if `ramas`=1: `ramas`←0 → SUNA; `semnal`←1; ring counter←RING_SEC.
  - SUNA:
    - `anulare` → IDLE; `semnal`←0; `activ`←0; no `gata`.
    - `start` is ignored.
    - On `tick`, the ring counter decrements.
    - On the tick where the ring counter is 1 → IDLE; `semnal`←0; `activ`←0; `gata`←1 for one cycle.
- Priority when events coincide: `anulare` > `start` > `tick`. A cancel always wins.
- `ramas` never underflows. No arithmetic wraps, since decrements are guarded.
- Total ring latency from an accepted `start`:
  - `semnal` rises `durata`×PRESCALE cycles after the `start` edge.
  - It stays high for RING_SEC×PRESCALE cycles.

Decomposition:
- Shared package `alarma_pkg`:
  - State enum {IDLE, NUMARA, SUNA}, 2 bits.
  - Default-parameter localparams.
- One sub-module, `debounce_buton` (parameter DEB_CYCLES):
  - Contains the synchronizer, the stability counter and the rising-edge pulse.
  - Inputs: `clock`, `reset`, `in`. Outputs: `nivel`, `apasat`.
  - Reusable for other front-panel buttons.

Test Plan (PRESCALE=4, RING_SEC=3, DEB_CYCLES=2):
- Normal run: `start` with `durata`=2 at cycle 0.
  - `activ`=1 and `ramas`=2 after edge 1; `ramas`=1 at cycle 5.
  - `semnal` rises at cycle 9 and is high for 12 cycles.
  - `gata` pulses once at cycle 21; then `activ`=0.
- Zero/idle start: `start` with `durata`=0 in IDLE → no state change; all outputs stay 0 for 20 cycles.
- Reload: `durata`=5 running; at `ramas`=3, `start` with `durata`=2.
  - `ramas`=2, and the next decrement comes exactly 4 cycles later.
  - `semnal` rises 8 cycles after the reload.
- Cancel with bounce: during SUNA, toggle `oprire` 1-0-1 with 1-cycle glitches, then hold it at 1.
  - Glitches are rejected.
  - The accepted press drops `semnal` and `activ` within DEB_CYCLES+4 cycles.
  - `gata` never pulses.
- Simultaneous events: `anulare` and `start` (`durata`=7) in the same cycle during NUMARA → IDLE, `ramas`=0.
- Async reset: assert `reset` mid-cycle during SUNA.
  - `semnal`, `activ` and `ramas` go to 0 before the next clock edge.
  - After release, the block stays idle until a new `start`.
